// File: rtl/alu_share_ctrl_if.sv
// Bundle between alu_share_ctrl, its two requesters (0 = execute, 1 = branch/address)
// and the shared combinational ALU. Per-port signals are packed [1:0] arrays.
interface alu_share_ctrl_if #(
  parameter int DW  = 32,
  parameter int OPW = 5
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][OPW-1:0] req_op;
  logic [1:0][DW-1:0]  req_a;
  logic [1:0][DW-1:0]  req_b;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DW-1:0]       rsp_out;
  logic                rsp_zero;
  logic [OPW-1:0]      alu_op;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [DW-1:0]       alu_out;
  logic                alu_zero;

  // master: requesters plus the ALU instance, i.e. everything around the controller
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_out, rsp_zero, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Two-port arbiter/sequencer for one shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_ctrl #(
  parameter int DW          = 32,
  parameter int OPW         = 5,
  parameter int EXEC_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic [OPW-1:0] op_r;
  logic [DW-1:0]  a_r, b_r, res_r;
  logic           zero_r, gnt_r, last_r;
  logic [CW-1:0]  cnt;
  logic           any_req, gnt, rr_last, accept, done, rsp_take;

`ifdef ALU_SHARE_RR_EN
  assign rr_last = last_r;
`else
  // fixed priority behaves as if port 1 always won last, so port 0 wins conflicts
  assign rr_last = last_r | 1'b1;
`endif

  assign any_req = (|bus.req_valid) & rst_n;
  assign gnt     = bus.req_valid[1] & (~bus.req_valid[0] | ~rr_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    accept        = 1'b0;
    done          = 1'b0;
    rsp_take      = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        bus.req_ready[gnt] = 1'b1;
        accept             = 1'b1;
        state_nx           = EXEC;
      end
      EXEC: if (cnt == '0) begin
        done     = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid[gnt_r] = 1'b1;
        if (bus.rsp_ready[gnt_r]) begin
          rsp_take = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      zero_r <= 1'b0;
      gnt_r  <= 1'b0;
      last_r <= 1'b1;
      cnt    <= '0;
    end else begin
      if (accept) begin
        op_r  <= bus.req_op[gnt];
        a_r   <= bus.req_a[gnt];
        b_r   <= bus.req_b[gnt];
        gnt_r <= gnt;
        cnt   <= CW'(EXEC_CYCLES - 1);
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        res_r  <= bus.alu_out;
        zero_r <= bus.alu_zero;
      end
      if (rsp_take) last_r <= gnt_r;
    end
  end

  // ALU inputs only move on acceptance, so the ALU sees stable operands outside EXEC too
  assign bus.alu_op   = op_r;
  assign bus.alu_a    = a_r;
  assign bus.alu_b    = b_r;
  assign bus.rsp_out  = res_r;
  assign bus.rsp_zero = zero_r;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: dut0 with EXEC_CYCLES=1, dut4 with EXEC_CYCLES=4,
// each driving a small behavioural ALU stub (add=0, sub=1, sll=2, beq=10 computes A-B).
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.DW(32), .OPW(5)) bus0 ();
  alu_share_ctrl_if #(.DW(32), .OPW(5)) bus4 ();

  alu_share_ctrl #(.DW(32), .OPW(5), .EXEC_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_share_ctrl #(.DW(32), .OPW(5), .EXEC_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00000: return a + b;
      5'b00001: return a - b;
      5'b00010: return a << b[4:0];
      5'b01010: return a - b;
      default:  return 32'h0;
    endcase
  endfunction

  assign bus0.alu_out  = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
  assign bus0.alu_zero = (bus0.alu_out == 32'h0);
  assign bus4.alu_out  = alu_f(bus4.alu_op, bus4.alu_a, bus4.alu_b);
  assign bus4.alu_zero = (bus4.alu_out == 32'h0);

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bus0.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", bus0.req_ready); end
    checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", bus0.rsp_valid); end
    checks++; if (bus0.rsp_out !== 32'h0) begin errors++; $display("FAIL reset_rsp_out: got %h want 0", bus0.rsp_out); end
    checks++; if (bus0.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero: got %b want 0", bus0.rsp_zero); end
    checks++; if (bus0.alu_op !== 5'h0) begin errors++; $display("FAIL reset_alu_op: got %h want 0", bus0.alu_op); end
    checks++; if ({bus0.alu_a, bus0.alu_b} !== 64'h0) begin errors++; $display("FAIL reset_alu_ab: got %h want 0", {bus0.alu_a, bus0.alu_b}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add;
    bus0.rsp_ready = 2'b01;
    bus0.req_op[0] = 5'b00000; bus0.req_a[0] = 32'd5; bus0.req_b[0] = 32'd7;
    bus0.req_valid = 2'b01;
    #1;
    checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready: got %b want 01", bus0.req_ready); end
    tick;
    bus0.req_valid = 2'b00;
    #1;
    checks++; if (bus0.req_ready !== 2'b00 || bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec_quiet: got rdy %b vld %b want 00 00", bus0.req_ready, bus0.rsp_valid); end
    checks++; if (bus0.alu_a !== 32'd5 || bus0.alu_b !== 32'd7) begin errors++; $display("FAIL add_alu_ab: got %0d %0d want 5 7", bus0.alu_a, bus0.alu_b); end
    tick;
    checks++; if (bus0.rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid: got %b want 01", bus0.rsp_valid); end
    checks++; if (bus0.rsp_out !== 32'd12 || bus0.rsp_zero !== 1'b0) begin errors++; $display("FAIL add_rsp_out: got %0d z%b want 12 z0", bus0.rsp_out, bus0.rsp_zero); end
    tick;
  endtask

  // cycle 3 after the previous acceptance: IDLE again, a new request is taken at once
  task automatic test_back_to_back;
    bus0.rsp_ready = 2'b10;
    bus0.req_op[1] = 5'b00000; bus0.req_a[1] = 32'd100; bus0.req_b[1] = 32'd23;
    bus0.req_valid = 2'b10;
    #1;
    checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL b2b_req_ready: got %b want 10", bus0.req_ready); end
    tick;
    bus0.req_valid = 2'b00;
    tick;
    checks++; if (bus0.rsp_valid !== 2'b10 || bus0.rsp_out !== 32'd123) begin errors++; $display("FAIL b2b_rsp: got %b %0d want 10 123", bus0.rsp_valid, bus0.rsp_out); end
    tick;
    checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL b2b_rsp_drop: got %b want 00", bus0.rsp_valid); end
  endtask

  task automatic test_branch;
    bus0.rsp_ready = 2'b11;
    bus0.req_op[1] = 5'b01010; bus0.req_a[1] = 32'h1234; bus0.req_b[1] = 32'h1234;
    bus0.req_valid = 2'b10;
    #1;
    checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL beq_req_ready: got %b want 10", bus0.req_ready); end
    tick;
    bus0.req_valid = 2'b00;
    checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL beq_exec_rsp: got %b want 00", bus0.rsp_valid); end
    tick;
    checks++; if (bus0.rsp_valid !== 2'b10) begin errors++; $display("FAIL beq_rsp_valid: got %b want 10", bus0.rsp_valid); end
    checks++; if (bus0.rsp_zero !== 1'b1 || bus0.rsp_out !== 32'h0) begin errors++; $display("FAIL beq_zero: got z%b %h want z1 0", bus0.rsp_zero, bus0.rsp_out); end
    tick;
  endtask

  task automatic test_conflict;
    logic exp_ord [4];
    logic ord [4];
    int left0 = 2, left1 = 2, n = 0, seen = 0;
`ifdef ALU_SHARE_RR_EN
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ord = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    ord = '{1'b0, 1'b0, 1'b0, 1'b0};
    bus0.rsp_ready = 2'b11;
    bus0.req_op[0] = 5'b00000; bus0.req_a[0] = 32'd1; bus0.req_b[0] = 32'd1;
    bus0.req_op[1] = 5'b00000; bus0.req_a[1] = 32'd2; bus0.req_b[1] = 32'd2;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      bus0.req_valid = {left1 > 0, left0 > 0};
      #1;
      if (bus0.req_ready != 2'b00) begin
        checks++; if (bus0.req_ready === 2'b11) begin errors++; $display("FAIL conf_one_ready: got %b want one-hot", bus0.req_ready); end
        if (n < 4) begin
          ord[n] = bus0.req_ready[1];
          if (bus0.req_ready[1]) left1--; else left0--;
          n++;
        end
      end
      if (bus0.rsp_valid != 2'b00) begin
        checks++;
        if (bus0.rsp_valid !== (2'b01 << ord[seen]) || bus0.rsp_out !== (ord[seen] ? 32'd4 : 32'd2)) begin
          errors++; $display("FAIL conf_rsp%0d: got %b %0d want port %0d", seen, bus0.rsp_valid, bus0.rsp_out, ord[seen]);
        end
        seen++;
      end
      tick;
    end
    bus0.req_valid = 2'b00;
    checks++; if (seen != 4) begin errors++; $display("FAIL conf_timeout: got %0d responses want 4", seen); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ord[k] !== exp_ord[k]) begin errors++; $display("FAIL conf_order%0d: got port %0d want port %0d", k, ord[k], exp_ord[k]); end
    end
  endtask

  task automatic test_backpressure;
    bus0.rsp_ready = 2'b00;
    bus0.req_op[0] = 5'b00001; bus0.req_a[0] = 32'd3; bus0.req_b[0] = 32'd5;
    bus0.req_op[1] = 5'b00000; bus0.req_a[1] = 32'd7; bus0.req_b[1] = 32'd7;
    bus0.req_valid = 2'b11;
    #1;
    checks++; if (bus0.req_ready !== 2'b01) begin errors++; $display("FAIL bp_req_ready: got %b want 01", bus0.req_ready); end
    tick;
    bus0.req_valid = 2'b10;
    tick;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus0.rsp_valid !== 2'b01 || bus0.rsp_out !== 32'hFFFF_FFFE || bus0.req_ready !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d: got vld %b out %h rdy %b want 01 fffffffe 00", c, bus0.rsp_valid, bus0.rsp_out, bus0.req_ready);
      end
      tick;
    end
    bus0.rsp_ready = 2'b01;
    tick;
    checks++; if (bus0.rsp_valid !== 2'b00 || bus0.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release: got vld %b rdy %b want 00 10", bus0.rsp_valid, bus0.req_ready); end
    bus0.req_valid = 2'b00;
  endtask

  task automatic test_exec4;
    int lat = 1;
    bus4.rsp_ready = 2'b01;
    bus4.req_op[0] = 5'b00010; bus4.req_a[0] = 32'd1; bus4.req_b[0] = 32'd31;
    bus4.req_valid = 2'b01;
    #1;
    checks++; if (bus4.req_ready !== 2'b01) begin errors++; $display("FAIL e4_req_ready: got %b want 01", bus4.req_ready); end
    tick;
    bus4.req_valid = 2'b00;
    checks++; if (bus4.alu_op !== 5'b00010 || bus4.alu_b !== 32'd31) begin errors++; $display("FAIL e4_alu_in: got %h %0d want 02 31", bus4.alu_op, bus4.alu_b); end
    while (bus4.rsp_valid == 2'b00 && lat < 20) begin
      tick;
      lat++;
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL e4_latency: got %0d want 5", lat); end
    checks++; if (bus4.rsp_valid !== 2'b01 || bus4.rsp_out !== 32'h8000_0000) begin errors++; $display("FAIL e4_rsp: got %b %h want 01 80000000", bus4.rsp_valid, bus4.rsp_out); end
    tick;
  endtask

  task automatic test_reset_mid_exec;
    bus0.rsp_ready = 2'b11;
    bus0.req_op[0] = 5'b00000; bus0.req_a[0] = 32'd9; bus0.req_b[0] = 32'd9;
    bus0.req_valid = 2'b01;
    tick;
    bus0.req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.alu_op !== 5'h0 || bus0.alu_a !== 32'h0 || bus0.alu_b !== 32'h0) begin errors++; $display("FAIL rst_alu: got %h %h %h want 0 0 0", bus0.alu_op, bus0.alu_a, bus0.alu_b); end
    checks++; if (bus0.rsp_out !== 32'h0 || bus0.rsp_zero !== 1'b0) begin errors++; $display("FAIL rst_rsp_out: got %h z%b want 0 z0", bus0.rsp_out, bus0.rsp_zero); end
    checks++; if (bus0.rsp_valid !== 2'b00 || bus0.req_ready !== 2'b00) begin errors++; $display("FAIL rst_hs: got vld %b rdy %b want 00 00", bus0.rsp_valid, bus0.req_ready); end
    tick;
    tick;
    checks++; if (bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_held_rsp: got %b want 00", bus0.rsp_valid); end
    rst_n = 1'b1;
    bus0.req_op[1] = 5'b00000; bus0.req_a[1] = 32'd2; bus0.req_b[1] = 32'd3;
    bus0.req_valid = 2'b10;
    #1;
    checks++; if (bus0.req_ready !== 2'b10) begin errors++; $display("FAIL rst_first_ready: got %b want 10", bus0.req_ready); end
    tick;
    bus0.req_valid = 2'b00;
    checks++; if (bus0.alu_a !== 32'd2 || bus0.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_first_accept: got a %0d vld %b want 2 00", bus0.alu_a, bus0.rsp_valid); end
    tick;
    checks++; if (bus0.rsp_valid !== 2'b10 || bus0.rsp_out !== 32'd5) begin errors++; $display("FAIL rst_first_rsp: got %b %0d want 10 5", bus0.rsp_valid, bus0.rsp_out); end
    tick;
  endtask

  initial begin
    bus0.req_valid = '0; bus0.rsp_ready = '0;
    bus0.req_op = '0; bus0.req_a = '0; bus0.req_b = '0;
    bus4.req_valid = '0; bus4.rsp_ready = '0;
    bus4.req_op = '0; bus4.req_a = '0; bus4.req_b = '0;
    test_reset;
    test_single_add;
    test_back_to_back;
    test_branch;
    test_conflict;
    test_backpressure;
    test_exec4;
    test_reset_mid_exec;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
